// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit display. It steps a digit index
//   through the digits at a fixed slot rate, presents the nibble for the current digit,
//   blanks the first cycles of each slot and double-buffers the display word. New data
//   reaches the visible word only at a frame boundary, or immediately when scanning is
//   stopped, so a frame never shows a mix of old and new data.
//
// Parameters
//   DIV         clock cycles per digit slot (>= 2)
//   BLANK       blanked cycles at the start of each slot (0 <= BLANK < DIV)
//   NUM_DIGITS  digits scanned (1..8); sel counts 0..NUM_DIGITS-1
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst         asynchronous reset, active-high
//   en          scan enable; when low the prescaler and sel hold
//   load        single-cycle strobe capturing data_in into the pending buffer
//   data_in     display word, digit i = data_in[4i+3:4i]
//   sel         current digit index, feeds the 3-to-8 digit decoder
//   digit       nibble of the active word selected by sel
//   blank       1 = display must be dark this cycle
//   frame_tick  one-cycle pulse on the first cycle after sel wraps to 0
//   load_ack    one-cycle pulse in the cycle the active word takes a new value
module digit_scan_ctrl #(
   parameter int unsigned DIV        = 50000,
   parameter int unsigned BLANK      = 4,
   parameter int unsigned NUM_DIGITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] data_in,
   output logic [2:0]  sel,
   output logic [3:0]  digit,
   output logic        blank,
   output logic        frame_tick,
   output logic        load_ack
);

   localparam int unsigned CW = $clog2(DIV);

   localparam logic [CW-1:0] CntLast  = CW'(DIV - 1);
   localparam logic [CW-1:0] BlankCnt = CW'(BLANK);
   localparam logic [CW-1:0] CntOne   = CW'(1);
   localparam logic [2:0]    SelLast  = 3'(NUM_DIGITS - 1);

   // Prescaler and digit index
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    sel_q, sel_d;

   // Double-buffered display word
   logic [31:0]   active_q, active_d;
   logic [31:0]   pending_q, pending_d;
   logic          pend_flag_q, pend_flag_d;

   // Registered outputs
   logic          blank_q, blank_d;
   logic          frame_tick_q, frame_tick_d;
   logic          load_ack_q, load_ack_d;

   // Decode of the current cycle
   logic          slot_end;
   logic          wrap;
   logic          merged_flag;
   logic [31:0]   merged_data;
   logic          commit;

   always_comb begin
      slot_end = en && (cnt_q == CntLast);
      wrap     = slot_end && (sel_q == SelLast);
   end

   // Scan position: cnt counts through the slot, sel advances at the slot end.
   always_comb begin
      cnt_d = cnt_q;
      sel_d = sel_q;
      if (en) begin
         if (slot_end) begin
            cnt_d = '0;
            sel_d = (sel_q == SelLast) ? 3'd0 : sel_q + 3'd1;
         end else begin
            cnt_d = cnt_q + CntOne;
         end
      end
   end

   // blank and frame_tick look at the upcoming position so they line up with cnt/sel.
   always_comb begin
      blank_d      = !en || (cnt_d < BlankCnt);
      frame_tick_d = wrap;
   end

   // A load in the same cycle as a commit must win over the stale pending word, so the
   // commit decision is made on the pending buffer as it would look after this load.
   always_comb begin
      merged_flag = pend_flag_q || load;
      merged_data = load ? data_in : pending_q;
      commit      = merged_flag && (wrap || !en);
   end

   always_comb begin
      active_d    = active_q;
      pending_d   = merged_data;
      pend_flag_d = merged_flag;
      load_ack_d  = 1'b0;
      if (commit) begin
         active_d    = merged_data;
         pend_flag_d = 1'b0;
         load_ack_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         sel_q        <= 3'd0;
         active_q     <= 32'd0;
         pending_q    <= 32'd0;
         pend_flag_q  <= 1'b0;
         blank_q      <= 1'b1;
         frame_tick_q <= 1'b0;
         load_ack_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         pend_flag_q  <= pend_flag_d;
         blank_q      <= blank_d;
         frame_tick_q <= frame_tick_d;
         load_ack_q   <= load_ack_d;
      end
   end

   // digit follows sel and active directly, with no extra register stage.
   always_comb begin
      sel        = sel_q;
      digit      = active_q[{sel_q, 2'b00} +: 4];
      blank      = blank_q;
      frame_tick = frame_tick_q;
      load_ack   = load_ack_q;
   end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for an 8-digit display.
- Sits directly upstream of the 3-to-8 digit-select decoder.
- Produces the 3-bit digit index `sel` that the decoder turns into a one-hot digit enable, plus the 4-bit nibble to show on that digit.
- Holds a double-buffered 32-bit display word so that new data is only committed at frame boundaries. This avoids tearing.

Parameters:
DIV, 50000, clock cycles per digit slot; legal range DIV >= 2
BLANK, 4, cycles at the start of each slot during which the display is blanked (anti-ghosting); legal range 0 <= BLANK < DIV
NUM_DIGITS, 8, number of digits scanned; legal range 1..8; sel counts 0..NUM_DIGITS-1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable
load  in  1  single-cycle strobe; captures data_in
data_in  in  32  display word; digit i = data_in[4i+3:4i]
sel  out  3  current digit index, to the 3-to-8 decoder
digit  out  4  nibble of the active word for digit sel
blank  out  1  1 = display must be dark this cycle
frame_tick  out  1  one-cycle pulse on the first cycle of a new frame (sel wrapped to 0)
load_ack  out  1  one-cycle pulse in the cycle the active word takes a new value

Behaviour:
- Reset, asynchronous on rst=1:
  - cnt=0, sel=0, active=0, pending=0, pend_flag=0.
  - Outputs: blank=1, frame_tick=0, load_ack=0, digit=0.
- Prescaler cnt (width clog2(DIV)):
  - With en=1, cnt increments each cycle.
  - At cnt==DIV-1, cnt returns to 0 and sel advances.
  - sel wraps from NUM_DIGITS-1 to 0.
- Hold: with en=0, cnt and sel hold their values.
- blank:
  - Registered: blank=1 when en=0, or when the next-state cnt < BLANK.
  - With BLANK=0, blank is 0 for the whole slot while enabled.
- digit:
  - Equals active[4*sel+3 : 4*sel], derived from registered active and sel.
  - Changes in the same cycle as sel or active; no extra latency.
- frame_tick: registered pulse, high exactly in the first cycle where sel==0 after a wrap from NUM_DIGITS-1. It is not asserted out of reset.
- Load / commit:
  - load=1 writes data_in into pending and sets pend_flag.
  - A load while pend_flag=1 overwrites pending (last writer wins).
- Commit event, when pend_flag=1 and either:
  - (a) the cycle in which sel wraps to 0, or
  - (b) en=0.
- On commit:
  - active <= pending, pend_flag <= 0.
  - load_ack=1 in the cycle active shows the new value.
- Simultaneous load and commit: the commit uses the incoming data_in, not the stale pending value. pend_flag ends at 0, and exactly one load_ack is issued.
- Load with en=0: active updates one cycle after the load cycle, with load_ack in that same cycle.
- en toggling mid-slot: cnt resumes from its held value and does not restart the slot. blank follows the rule above.
- NUM_DIGITS=1: sel stays 0, and frame_tick pulses every DIV cycles.
- rst asserted mid-frame: all state returns to reset values immediately and any pending load is discarded. Scanning restarts at sel=0, cnt=0 after rst deasserts.

Test Plan (DIV=4, BLANK=1, NUM_DIGITS=8 unless stated):
- Reset/idle: hold rst 3 cycles, release with en=0 -> sel=0, blank=1, digit=0, frame_tick=0, load_ack=0, all stable for 10 cycles.
- Scan sequence: en=1 -> sel steps 0,1,...,7,0 every 4 cycles. blank=1 for the first cycle of each slot, then 0 for 3 cycles. frame_tick is a single pulse on each return to sel=0, i.e. every 32 cycles.
- Deferred commit: with en=1 and sel=3, load data_in=32'h76543210 -> digit is unchanged until the wrap. At the sel=0 cycle load_ack=1, then digit reads 0,1,2,...,7 across the frame.
- Overwrite and same-cycle load: load 32'h11111111 then 32'h22222222 mid-frame -> one load_ack at the wrap, active=32'h22222222. Separately, load 32'hAAAAAAAA in the exact wrap cycle -> active=32'hAAAAAAAA with a single load_ack.
- Disabled-path commit: en=0, load 32'h0000000F -> load_ack and active update next cycle, sel=0 gives digit=4'hF, blank=1 throughout. Then en=1 mid-slot: cnt resumes without restarting the slot.
- Async reset mid-operation: assert rst between clock edges at sel=5 with pend_flag=1 -> outputs go to reset values before the next edge. After release no load_ack occurs and active=0.
- Parameter corners: NUM_DIGITS=1, DIV=2, BLANK=0 -> sel constant 0, frame_tick every 2 cycles, blank=0 while en=1.
